// File: rtl/axis_tdest_to_vector.sv
// Collects N = VEC_BYTES/AXIS_BYTES beats addressed to one AXI-Stream destination into a
// parallel vector; short or long frames are discarded and flagged with frame_err.
module axis_tdest_to_vector #(
    parameter int VEC_BYTES   = 2,
    parameter int AXIS_BYTES  = 1,
    parameter int MSB_FIRST   = 0,
    parameter int TDEST       = 0,
    parameter int TDEST_WIDTH = 1
) (
    input  logic                     clk,
    input  logic                     sresetn,
    input  logic [AXIS_BYTES*8-1:0]  s_axis_tdata,
    input  logic [AXIS_BYTES-1:0]    s_axis_tkeep,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    input  logic                     s_axis_tlast,
    input  logic [TDEST_WIDTH-1:0]   s_axis_tdest,
    output logic [VEC_BYTES*8-1:0]   vec,
    output logic                     vec_valid,
    output logic                     frame_err
);

    localparam int unsigned N      = VEC_BYTES / AXIS_BYTES;
    localparam int unsigned CTR_W  = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned BEAT_W = AXIS_BYTES * 8;
    localparam int unsigned VEC_W  = VEC_BYTES * 8;

    localparam logic [CTR_W-1:0] CTR_INIT = (MSB_FIRST != 0) ? CTR_W'(N - 1) : '0;
    localparam logic [CTR_W-1:0] CTR_LAST = (MSB_FIRST != 0) ? '0 : CTR_W'(N - 1);
    localparam logic [TDEST_WIDTH-1:0] TDEST_MATCH = TDEST_WIDTH'(TDEST);

    localparam logic [0:0] ST_SYNC   = 1'b0;
    localparam logic [0:0] ST_RESYNC = 1'b1;

    if ((AXIS_BYTES < 1) || (VEC_BYTES < AXIS_BYTES) || ((VEC_BYTES % AXIS_BYTES) != 0)) begin : g_bad_params
        $error("axis_tdest_to_vector: VEC_BYTES must be a non-zero multiple of AXIS_BYTES");
    end

    logic [0:0]       state_q, state_d;
    logic [CTR_W-1:0] ctr_q, ctr_d;
    logic [VEC_W-1:0] staging_q, staging_d;
    logic [VEC_W-1:0] vec_q, vec_d;
    logic             vec_valid_q, vec_valid_d;
    logic             frame_err_q, frame_err_d;

    logic             beat_ok;
    logic             at_last;
    logic [CTR_W-1:0] ctr_step;
    logic [VEC_W-1:0] merged;

    // Byte enables carry no meaning here: every beat is taken as fully populated.
    logic unused_tkeep;
    assign unused_tkeep = ^s_axis_tkeep;

    assign s_axis_tready = sresetn;
    assign beat_ok       = s_axis_tvalid && sresetn && (s_axis_tdest == TDEST_MATCH);
    assign at_last       = (ctr_q == CTR_LAST);
    assign ctr_step      = (MSB_FIRST != 0) ? (ctr_q - CTR_W'(1)) : (ctr_q + CTR_W'(1));

    // Staging with the current beat dropped into the slot selected by ctr.
    always_comb begin
        merged = staging_q;
        for (int unsigned i = 0; i < N; i++) begin
            if (ctr_q == CTR_W'(i)) begin
                merged[i*BEAT_W +: BEAT_W] = s_axis_tdata;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ctr_d       = ctr_q;
        staging_d   = staging_q;
        vec_d       = vec_q;
        vec_valid_d = 1'b0;
        frame_err_d = 1'b0;

        if (beat_ok) begin
            case (state_q)
                ST_SYNC: begin
                    if (!at_last && !s_axis_tlast) begin
                        staging_d = merged;
                        ctr_d     = ctr_step;
                    end else if (at_last && s_axis_tlast) begin
                        vec_d       = merged;
                        vec_valid_d = 1'b1;
                        ctr_d       = CTR_INIT;
                    end else if (!at_last && s_axis_tlast) begin
                        frame_err_d = 1'b1;
                        ctr_d       = CTR_INIT;
                    end else begin
                        frame_err_d = 1'b1;
                        ctr_d       = CTR_INIT;
                        state_d     = ST_RESYNC;
                    end
                end
                default: begin
                    if (s_axis_tlast) begin
                        state_d = ST_SYNC;
                        ctr_d   = CTR_INIT;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!sresetn) begin
            state_q     <= ST_SYNC;
            ctr_q       <= CTR_INIT;
            staging_q   <= '0;
            vec_q       <= '0;
            vec_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ctr_q       <= ctr_d;
            staging_q   <= staging_d;
            vec_q       <= vec_d;
            vec_valid_q <= vec_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign vec       = vec_q;
    assign vec_valid = vec_valid_q;
    assign frame_err = frame_err_q;

    a_strobes_exclusive: assert property (@(posedge clk) disable iff (!sresetn)
        !(vec_valid_q && frame_err_q));

endmodule

// File: tb/tb_axis_tdest_to_vector.sv
// Directed bench for axis_tdest_to_vector: LSB-first, MSB-first and single-beat instances
// share one stream; expected strobes are queued at drive time and matched on output.
module tb_axis_tdest_to_vector;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        sresetn;
    logic [7:0]  tdata;
    logic [0:0]  tkeep;
    logic        tvalid;
    logic        tlast;
    logic [1:0]  tdest;

    logic        tready0, tready1, tready2;
    logic [31:0] vec0, vec1;
    logic [7:0]  vec2;
    logic        vv0, vv1, vv2;
    logic        fe0, fe1, fe2;

    axis_tdest_to_vector #(.VEC_BYTES(4), .AXIS_BYTES(1), .MSB_FIRST(0), .TDEST(2), .TDEST_WIDTH(2)) dut_lsb (
        .clk(clk), .sresetn(sresetn), .s_axis_tdata(tdata), .s_axis_tkeep(tkeep),
        .s_axis_tvalid(tvalid), .s_axis_tready(tready0), .s_axis_tlast(tlast), .s_axis_tdest(tdest),
        .vec(vec0), .vec_valid(vv0), .frame_err(fe0));

    axis_tdest_to_vector #(.VEC_BYTES(4), .AXIS_BYTES(1), .MSB_FIRST(1), .TDEST(2), .TDEST_WIDTH(2)) dut_msb (
        .clk(clk), .sresetn(sresetn), .s_axis_tdata(tdata), .s_axis_tkeep(tkeep),
        .s_axis_tvalid(tvalid), .s_axis_tready(tready1), .s_axis_tlast(tlast), .s_axis_tdest(tdest),
        .vec(vec1), .vec_valid(vv1), .frame_err(fe1));

    axis_tdest_to_vector #(.VEC_BYTES(1), .AXIS_BYTES(1), .MSB_FIRST(0), .TDEST(2), .TDEST_WIDTH(2)) dut_one (
        .clk(clk), .sresetn(sresetn), .s_axis_tdata(tdata), .s_axis_tkeep(tkeep),
        .s_axis_tvalid(tvalid), .s_axis_tready(tready2), .s_axis_tlast(tlast), .s_axis_tdest(tdest),
        .vec(vec2), .vec_valid(vv2), .frame_err(fe2));

    typedef struct {
        bit          is_err;
        logic [31:0] vec;
        int unsigned cyc;
    } ev_t;

    ev_t q0[$];
    ev_t q1[$];
    ev_t q2[$];

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc = 0;
    int unsigned beat_cyc = 0;
    logic [31:0] expv [3];
    logic [31:0] held [3];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_ev(input int id, input bit is_err, input logic [31:0] v);
        ev_t e;
        e.is_err = is_err;
        e.vec    = v;
        e.cyc    = beat_cyc;
        case (id)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic push_vec(input int id, input logic [31:0] v);
        push_ev(id, 1'b0, v);
        expv[id] = v;
    endtask

    task automatic push_err(input int id);
        push_ev(id, 1'b1, expv[id]);
    endtask

    task automatic mon_dut(input int id, input logic vv, input logic fe, input logic [31:0] v);
        ev_t e;
        bit  have;
        have = 1'b0;
        if (vv || fe) begin
            case (id)
                0:       if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
                1:       if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
                default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
            endcase
            if (have) begin
                chk($sformatf("dut%0d_strobes{vv,fe}", id), {30'b0, vv, fe}, {30'b0, !e.is_err, e.is_err});
                chk($sformatf("dut%0d_vec_at_event", id), v, e.vec);
                chk($sformatf("dut%0d_event_cycle", id), 32'(cyc), 32'(e.cyc));
                held[id] = e.vec;
            end else begin
                chk($sformatf("dut%0d_unexpected_event{vv,fe}", id), {30'b0, vv, fe}, 32'h0);
            end
        end else begin
            chk($sformatf("dut%0d_vec_hold", id), v, held[id]);
        end
    endtask

    always @(negedge clk) begin
        if (sresetn === 1'b1) begin
            mon_dut(0, vv0, fe0, vec0);
            mon_dut(1, vv1, fe1, vec1);
            mon_dut(2, vv2, fe2, {24'h0, vec2});
        end
    end

    task automatic send_beat(input logic [7:0] d, input logic l, input logic [1:0] dst, input int unsigned gap);
        repeat (gap) begin @(posedge clk); #1; end
        tdata  = d;
        tlast  = l;
        tdest  = dst;
        tkeep  = 1'($urandom_range(1, 0));
        tvalid = 1'b1;
        @(posedge clk); #1;
        beat_cyc = cyc;
        tvalid = 1'b0;
        tlast  = 1'b0;
        tdata  = 8'($urandom);
        tdest  = 2'($urandom);
    endtask

    // Good 4-beat frame on tdest 2; the single-beat instance flags its first beat as a long frame.
    task automatic frame4(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                          input logic [7:0] b3, input int unsigned max_gap);
        send_beat(b0, 1'b0, 2'd2, $urandom_range(max_gap, 0));
        push_err(2);
        send_beat(b1, 1'b0, 2'd2, $urandom_range(max_gap, 0));
        send_beat(b2, 1'b0, 2'd2, $urandom_range(max_gap, 0));
        send_beat(b3, 1'b1, 2'd2, $urandom_range(max_gap, 0));
        push_vec(0, {b3, b2, b1, b0});
        push_vec(1, {b0, b1, b2, b3});
    endtask

    task automatic check_in_reset();
        chk("rst_tready0", {31'b0, tready0}, 32'h0);
        chk("rst_tready1", {31'b0, tready1}, 32'h0);
        chk("rst_tready2", {31'b0, tready2}, 32'h0);
        chk("rst_vec0", vec0, 32'h0);
        chk("rst_vec1", vec1, 32'h0);
        chk("rst_vec2", {24'h0, vec2}, 32'h0);
        chk("rst_strobes", {26'b0, vv0, vv1, vv2, fe0, fe1, fe2}, 32'h0);
    endtask

    task automatic do_reset(input int unsigned ncyc);
        sresetn = 1'b0;
        tvalid  = 1'b0;
        repeat (ncyc) begin
            @(posedge clk); #1;
            check_in_reset();
        end
        for (int i = 0; i < 3; i++) begin
            expv[i] = '0;
            held[i] = '0;
        end
        sresetn = 1'b1;
        #1;
        chk("tready_after_reset", {29'b0, tready0, tready1, tready2}, 32'h7);
    endtask

    initial begin
        sresetn = 1'b0;
        tvalid  = 1'b0;
        tlast   = 1'b0;
        tdata   = '0;
        tkeep   = '0;
        tdest   = '0;
        for (int i = 0; i < 3; i++) begin
            expv[i] = '0;
            held[i] = '0;
        end
        @(posedge clk); #1;
        do_reset(3);

        // Basic frame, back to back.
        frame4(8'h11, 8'h22, 8'h33, 8'h44, 0);
        // Random gaps between beats.
        frame4(8'hA1, 8'hB2, 8'hC3, 8'hD4, 3);

        // Foreign-destination beats (one with tlast) interleaved with a good frame.
        send_beat(8'h11, 1'b0, 2'd2, 1);
        push_err(2);
        send_beat(8'h5E, 1'b0, 2'd3, 1);
        send_beat(8'h22, 1'b0, 2'd2, 0);
        send_beat(8'h6E, 1'b1, 2'd3, 0);
        send_beat(8'h33, 1'b0, 2'd2, 2);
        send_beat(8'h7E, 1'b0, 2'd1, 0);
        send_beat(8'h44, 1'b1, 2'd2, 0);
        push_vec(0, 32'h44332211);
        push_vec(1, 32'h11223344);

        // Whole frame on another destination: nothing may happen.
        send_beat(8'h91, 1'b0, 2'd3, 1);
        send_beat(8'h92, 1'b0, 2'd3, 0);
        send_beat(8'h93, 1'b0, 2'd3, 0);
        send_beat(8'h94, 1'b1, 2'd3, 0);

        // Short frame, then recovery.
        send_beat(8'hAA, 1'b0, 2'd2, 1);
        push_err(2);
        send_beat(8'hBB, 1'b1, 2'd2, 0);
        push_err(0);
        push_err(1);
        frame4(8'h01, 8'h02, 8'h03, 8'h04, 1);

        // Long frame: error after the 4th beat, 5th beat dropped, then recovery.
        send_beat(8'hE1, 1'b0, 2'd2, 2);
        push_err(2);
        send_beat(8'hE2, 1'b0, 2'd2, 0);
        send_beat(8'hE3, 1'b0, 2'd2, 0);
        send_beat(8'hE4, 1'b0, 2'd2, 0);
        push_err(0);
        push_err(1);
        send_beat(8'hE5, 1'b1, 2'd2, 1);
        frame4(8'hF1, 8'hF2, 8'hF3, 8'hF4, 0);

        // Single-beat frames: complete only for the N=1 instance.
        send_beat(8'h5A, 1'b1, 2'd2, 1);
        push_err(0);
        push_err(1);
        push_vec(2, 32'h0000005A);
        send_beat(8'h5B, 1'b0, 2'd2, 0);
        push_err(2);
        send_beat(8'h5C, 1'b1, 2'd2, 0);
        push_err(0);
        push_err(1);

        // Reset in the middle of a frame; the partial frame must vanish silently.
        send_beat(8'h99, 1'b0, 2'd2, 1);
        push_err(2);
        send_beat(8'h9A, 1'b0, 2'd2, 0);
        do_reset(2);
        frame4(8'h31, 8'h32, 8'h33, 8'h34, 2);

        repeat (6) begin @(posedge clk); #1; end
        chk("dut0_pending_events", 32'(q0.size()), 32'h0);
        chk("dut1_pending_events", 32'(q1.size()), 32'h0);
        chk("dut2_pending_events", 32'(q2.size()), 32'h0);
        chk("final_vec0", vec0, 32'h34333231);
        chk("final_vec1", vec1, 32'h31323334);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
